// File: rtl/compn_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : compn_ctrl_if
//  Description : Comparator data/enable/done bus between the compare
//                initiator (master) and the comparator unit (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface compn_ctrl_if;
    logic [7:0] data_out;    // {A,B} operands towards the comparator
    logic       enable_out;  // comparator enable
    logic [3:0] ab_in;       // comparator result
    logic       done_in;     // comparator done, asynchronous to the initiator clock

    modport master (
        output data_out,
        output enable_out,
        input  ab_in,
        input  done_in
    );

    modport slave (
        input  data_out,
        input  enable_out,
        output ab_in,
        output done_in
    );
endinterface
`default_nettype wire

// File: rtl/compn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : compn_ctrl
//  Description : Initiator side of the comparator enable/done handshake.
//                Latches {A,B} on a request, raises enable one cycle later,
//                waits for the synchronised done, captures ab, drops enable,
//                waits for done to clear and then pulses result_valid.
//                Optional handshake watchdog: define COMPN_CTRL_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module compn_ctrl #(
    parameter int INPUTSIZE      = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 start,
    input  wire logic [INPUTSIZE-1:0] a_in,
    input  wire logic [INPUTSIZE-1:0] b_in,
    output logic                      busy,
    output logic                      result_valid,
    output logic [3:0]                result,
    output logic                      timeout_err,
    compn_ctrl_if.master              cmp
);

    // The comparator bus is a fixed 8-bit {A,B} pack; reject other shapes early.
    if (INPUTSIZE != 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_param_check
        $error("compn_ctrl: unsupported INPUTSIZE/TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_STROBE  = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_sync1;
    logic       r_done_s;
    logic [7:0] r_data_out;
    logic       r_enable;
    logic [3:0] r_result;
    logic       r_valid;
    logic       w_load;
    logic       w_capture;
    logic       w_enable_nxt;
    logic       w_valid_nxt;
    logic       w_cnt_clr;

`ifdef COMPN_CTRL_TIMEOUT_EN
    logic [7:0] r_wait_cnt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic       w_expired;

    assign w_expired = (r_wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Wait counter: restarts on entry to STROBE/RELEASE, counts while waiting there.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 8'd0;
        end else if (w_cnt_clr) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == S_STROBE || r_state == S_RELEASE) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Abort pulse register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_nxt;
        end
    end

    assign timeout_err = r_timeout;
`else
    assign timeout_err = 1'b0;
`endif

    // done_in crosses from the comparator domain; two flops before any use.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b0;
            r_done_s <= 1'b0;
        end else begin
            r_sync1  <= cmp.done_in;
            r_done_s <= r_sync1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next values of the registered handshake outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_enable_nxt = 1'b0;
        w_valid_nxt  = 1'b0;
        w_cnt_clr    = 1'b0;
`ifdef COMPN_CTRL_TIMEOUT_EN
        w_timeout_nxt = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                // Data has been stable for a full cycle; enable rises now.
                w_enable_nxt = 1'b1;
                w_cnt_clr    = 1'b1;
                w_state_nxt  = S_STROBE;
            end
            S_STROBE: begin
                if (r_done_s) begin
                    w_capture   = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_RELEASE;
`ifdef COMPN_CTRL_TIMEOUT_EN
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
`endif
                end else begin
                    w_enable_nxt = 1'b1;
                end
            end
            S_RELEASE: begin
                if (!r_done_s) begin
                    w_valid_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
`ifdef COMPN_CTRL_TIMEOUT_EN
                end else if (w_expired) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output registers: operand pack, result capture, enable and valid pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= 8'd0;
            r_result   <= 4'd0;
            r_enable   <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            if (w_load) begin
                r_data_out <= {a_in, b_in};
            end
            if (w_capture) begin
                r_result <= cmp.ab_in;
            end
            r_enable <= w_enable_nxt;
            r_valid  <= w_valid_nxt;
        end
    end

    assign busy           = (r_state != S_IDLE);
    assign result_valid   = r_valid;
    assign result         = r_result;
    assign cmp.data_out   = r_data_out;
    assign cmp.enable_out = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_compn_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_compn_ctrl
//  Description : Self-checking bench for compn_ctrl. A delayed-responder model
//                answers the enable/done handshake; expected result, operand
//                bus and request latency are derived per transaction from the
//                responder delays (7 + rise delay + fall delay edges).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_compn_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a_in;
    logic [3:0] b_in;
    logic       busy;
    logic       result_valid;
    logic [3:0] result;
    logic       timeout_err;

    compn_ctrl_if u_bus ();

    compn_ctrl #(
        .INPUTSIZE      (4),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .timeout_err  (timeout_err),
        .cmp          (u_bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder: done follows enable after rise_dly/fall_dly edges; ab is only
    // meaningful while done is high, garbage otherwise.
    int         rise_dly = 0;
    int         fall_dly = 0;
    int         rcnt     = 0;
    logic [3:0] resp_ab  = 4'd0;

    initial begin
        u_bus.done_in = 1'b0;
        u_bus.ab_in   = 4'd0;
    end

    always @(posedge clk) begin
        #1;
        if (u_bus.enable_out === 1'b0 || u_bus.enable_out === 1'b1) begin
            if (u_bus.enable_out !== u_bus.done_in) begin
                if (rcnt >= (u_bus.enable_out ? rise_dly : fall_dly)) begin
                    u_bus.done_in = u_bus.enable_out;
                    rcnt = 0;
                end else begin
                    rcnt++;
                end
            end else begin
                rcnt = 0;
            end
        end
        u_bus.ab_in = u_bus.done_in ? resp_ab : 4'($urandom);
    end

    // One request; called at a negedge, returns at the negedge where
    // result_valid is seen (or the wait bound expires).
    task automatic run_req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] ab,
                           input int d, input int f, output int rv_cyc);
        int n;
        bit seen;
        rise_dly = d;
        fall_dly = f;
        resp_ab  = ab;
        start    = 1'b1;
        a_in     = a;
        b_in     = b;
        @(negedge clk);
        start = 1'b0;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 200) begin
            if (result_valid === 1'b1) begin
                seen = 1'b1;
            end else begin
                chk("busy_in_op", busy, 1);
                chk("data_out_hold", u_bus.data_out, {a, b});
                chk("no_timeout", timeout_err, 0);
                if (n == 0) chk("enable_in_setup", u_bus.enable_out, 0);
                if (n == 1) chk("enable_in_strobe", u_bus.enable_out, 1);
                start = ($urandom_range(0, 3) == 0);
                a_in  = 4'($urandom);
                b_in  = 4'($urandom);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        chk("rv_seen", seen, 1);
        chk("latency", n, 7 + d + f);
        chk("result", result, ab);
        chk("busy_after", busy, 0);
        rv_cyc = cyc;
    endtask

    int c1, c2;
    logic [3:0] last_ab;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a_in  = 4'd0;
        b_in  = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_data", u_bus.data_out, 0);
        chk("rst_enable", u_bus.enable_out, 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic compare with ideal responder.
        run_req(4'h9, 4'h3, 4'h1, 0, 0, c1);
        last_ab = 4'h1;
        @(negedge clk);
        chk("rv_one_cycle", result_valid, 0);
        chk("idle_busy", busy, 0);

        // Slow responder, start pulses while busy are ignored.
        run_req(4'h9, 4'h3, 4'hA, 10, 0, c1);
        last_ab = 4'hA;
        @(negedge clk);
        chk("idle_after_slow", busy, 0);

        // Back-to-back with start held into the result_valid cycle.
        run_req(4'h5, 4'h5, 4'h2, 0, 0, c1);
        run_req(4'h2, 4'h7, 4'h4, 0, 0, c2);
        chk("b2b_spacing", c2 - c1, 8);
        last_ab = 4'h4;

        // Randomised transactions with varying responder delays and gaps.
        for (int i = 0; i < 24; i++) begin
            logic [3:0] ra, rb, rab;
            int gap;
            ra  = 4'($urandom);
            rb  = 4'($urandom);
            rab = 4'($urandom);
            run_req(ra, rb, rab, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), c1);
            last_ab = rab;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                chk("gap_idle", busy, 0);
                chk("gap_no_rv", result_valid, 0);
            end
        end

        // Reset in STROBE: enable drops at that edge, no result_valid.
        rise_dly = 1000;
        start = 1'b1;
        a_in  = 4'hC;
        b_in  = 4'h6;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_enable", u_bus.enable_out, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_enable", u_bus.enable_out, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_result", result, 0);
        chk("midrst_data", u_bus.data_out, 0);
        chk("midrst_valid", result_valid, 0);
        rst = 1'b0;
        rise_dly = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("post_rst_no_rv", result_valid, 0);
            chk("post_rst_idle", busy, 0);
        end
        last_ab = 4'h0;

`ifdef COMPN_CTRL_TIMEOUT_EN
        // Stuck responder: abort 16 edges after enable rises.
        run_req(4'h1, 4'h2, 4'h7, 0, 0, c1);
        last_ab  = 4'h7;
        rise_dly = 1000;
        start = 1'b1;
        a_in  = 4'h3;
        b_in  = 4'h4;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 17; k++) begin
            @(negedge clk);
            chk("tmo_wait_none", timeout_err, 0);
            chk("tmo_wait_busy", busy, 1);
        end
        @(negedge clk);
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_enable", u_bus.enable_out, 0);
        chk("tmo_idle", busy, 0);
        chk("tmo_result", result, last_ab);
        chk("tmo_no_rv", result_valid, 0);
        @(negedge clk);
        chk("tmo_one_cycle", timeout_err, 0);
        rise_dly = 0;
`else
        chk("final_result", result, last_ab);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
